// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns the stage's memory op into a req/ack bus
// transaction, stalls the pipeline until it completes, and steers byte lanes.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_type,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_STOR = 2'b10;

  localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic        is_load, is_store, is_op, misaligned;
  logic [1:0]  sh;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] sd;
  logic [31:0] ld_result;

  assign is_load  = (mem_type == MEM_LOAD);
  assign is_store = (mem_type == MEM_STOR);
  assign is_op    = is_load | is_store;
  assign sh       = mem_addr[1:0];

  // Alignment check and store lane steering
  always_comb begin
    misaligned = 1'b0;
    st_be      = 4'hF;
    st_wdata   = mem_wdata;
    case (mem_size)
      2'b00: begin
        st_be    = 4'b0001 << sh;
        st_wdata = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = mem_addr[0];
        st_be      = 4'b0011 << sh;
        st_wdata   = {2{mem_wdata[15:0]}};
      end
      default: begin
        misaligned = |sh;
      end
    endcase
  end

  // Load extraction and extension from the raw bus word
  always_comb begin
    sd        = bus_rdata >> {sh, 3'b000};
    ld_result = sd;
    case (mem_size)
      2'b00:   ld_result = mem_signed ? {{24{sd[7]}}, sd[7:0]}  : {24'h0, sd[7:0]};
      2'b01:   ld_result = mem_signed ? {{16{sd[15]}}, sd[15:0]} : {16'h0, sd[15:0]};
      default: ld_result = sd;
    endcase
  end

  // Next-state and combinational stall
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_op && !misaligned) begin
          mem_stall = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (bus_ack || (cnt_q == CNT_LAST)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign addr_err  = is_op && misaligned;
  assign mem_rdata = (state_q == S_DONE) ? rdata_q : 32'h0;
  assign bus_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_REQ) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_be    <= is_store ? st_be : 4'hF;
            bus_wdata <= is_store ? st_wdata : 32'h0;
            cnt_q     <= '0;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            rdata_q <= bus_we ? 32'h0 : ld_result;
          end else if (cnt_q == CNT_LAST) begin
            bus_req <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
